// File: rtl/dmem_arbiter.sv
// Round-robin two-port arbiter/sequencer for the 32-bit data memory.
// Formats byte/half/word stores and loads, and rejects misaligned or illegal accesses.
module dmem_arbiter #(
  parameter int unsigned DM_ADDRESS = 9,
  parameter int unsigned DATA_W     = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  p0_req,
  input  logic                  p0_we,
  input  logic [DM_ADDRESS-1:0] p0_addr,
  input  logic [DATA_W-1:0]     p0_wdata,
  input  logic [2:0]            p0_funct3,
  output logic                  p0_ack,
  output logic                  p0_err,
  output logic [DATA_W-1:0]     p0_rdata,
  input  logic                  p1_req,
  input  logic                  p1_we,
  input  logic [DM_ADDRESS-1:0] p1_addr,
  input  logic [DATA_W-1:0]     p1_wdata,
  input  logic [2:0]            p1_funct3,
  output logic                  p1_ack,
  output logic                  p1_err,
  output logic [DATA_W-1:0]     p1_rdata,
  output logic [DM_ADDRESS-1:0] mem_addr,
  output logic [DATA_W-1:0]     mem_wdata,
  output logic [3:0]            mem_we,
  output logic                  mem_re,
  input  logic [DATA_W-1:0]     mem_rdata
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ACCESS = 2'd1;
  localparam logic [1:0] S_RESP   = 2'd2;

  logic [1:0]            state, state_nx;
  logic                  last_grant, last_grant_nx;
  logic                  id_q, id_nx;
  logic                  we_q, we_nx;
  logic [1:0]            lane_q, lane_nx;
  logic [2:0]            f3_q, f3_nx;
  logic                  legal_q, legal_nx;
  logic [DM_ADDRESS-1:0] mem_addr_nx;
  logic [DATA_W-1:0]     mem_wdata_nx;
  logic [3:0]            mem_we_q, mem_we_nx;
  logic                  mem_re_q, mem_re_nx;
  logic                  p0_ack_nx, p1_ack_nx, p0_err_nx, p1_err_nx;

  logic                  gnt;
  logic                  sel_we;
  logic [DM_ADDRESS-1:0] sel_addr;
  logic [DATA_W-1:0]     sel_wdata;
  logic [2:0]            sel_f3;
  logic                  sel_legal;
  logic [3:0]            sel_strb;
  logic [DATA_W-1:0]     sel_wrep;

  logic [7:0]            ld_byte;
  logic [15:0]           ld_half;
  logic [DATA_W-1:0]     ld_fmt;
  logic                  ld_valid;

  function automatic logic legal_fn(input logic we, input logic [2:0] f3, input logic [1:0] lo);
    case (f3)
      3'b000:  legal_fn = 1'b1;
      3'b001:  legal_fn = ~lo[0];
      3'b010:  legal_fn = (lo == 2'b00);
      3'b100:  legal_fn = ~we;
      3'b101:  legal_fn = ~we & ~lo[0];
      default: legal_fn = 1'b0;
    endcase
  endfunction

  // Winner selection and store formatting from the winning port's fields
  always_comb begin
    gnt       = (p0_req && p1_req) ? ~last_grant : p1_req;
    sel_we    = gnt ? p1_we     : p0_we;
    sel_addr  = gnt ? p1_addr   : p0_addr;
    sel_wdata = gnt ? p1_wdata  : p0_wdata;
    sel_f3    = gnt ? p1_funct3 : p0_funct3;
    sel_legal = legal_fn(sel_we, sel_f3, sel_addr[1:0]);
    case (sel_f3[1:0])
      2'b00: begin
        sel_strb = 4'b0001 << sel_addr[1:0];
        sel_wrep = {4{sel_wdata[7:0]}};
      end
      2'b01: begin
        sel_strb = 4'b0011 << {sel_addr[1], 1'b0};
        sel_wrep = {2{sel_wdata[15:0]}};
      end
      default: begin
        sel_strb = 4'b1111;
        sel_wrep = sel_wdata;
      end
    endcase
  end

  always_comb begin
    state_nx      = state;
    last_grant_nx = last_grant;
    id_nx         = id_q;
    we_nx         = we_q;
    lane_nx       = lane_q;
    f3_nx         = f3_q;
    legal_nx      = legal_q;
    mem_addr_nx   = '0;
    mem_wdata_nx  = '0;
    mem_we_nx     = 4'b0000;
    mem_re_nx     = 1'b0;
    p0_ack_nx     = 1'b0;
    p1_ack_nx     = 1'b0;
    p0_err_nx     = 1'b0;
    p1_err_nx     = 1'b0;
    case (state)
      S_IDLE: begin
        if (p0_req || p1_req) begin
          state_nx    = S_ACCESS;
          id_nx       = gnt;
          we_nx       = sel_we;
          lane_nx     = sel_addr[1:0];
          f3_nx       = sel_f3;
          legal_nx    = sel_legal;
          mem_addr_nx = {sel_addr[DM_ADDRESS-1:2], 2'b00};
          if (sel_legal && sel_we) begin
            mem_we_nx    = sel_strb;
            mem_wdata_nx = sel_wrep;
          end
          mem_re_nx = sel_legal & ~sel_we;
        end
      end
      S_ACCESS: begin
        state_nx  = S_RESP;
        p0_ack_nx = ~id_q;
        p1_ack_nx = id_q;
        p0_err_nx = ~id_q & ~legal_q;
        p1_err_nx = id_q & ~legal_q;
      end
      S_RESP: begin
        state_nx      = S_IDLE;
        last_grant_nx = id_q;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_IDLE;
      last_grant <= 1'b1;
      id_q       <= 1'b0;
      we_q       <= 1'b0;
      lane_q     <= 2'b00;
      f3_q       <= 3'b000;
      legal_q    <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      mem_we_q   <= 4'b0000;
      mem_re_q   <= 1'b0;
      p0_ack     <= 1'b0;
      p1_ack     <= 1'b0;
      p0_err     <= 1'b0;
      p1_err     <= 1'b0;
    end else begin
      state      <= state_nx;
      last_grant <= last_grant_nx;
      id_q       <= id_nx;
      we_q       <= we_nx;
      lane_q     <= lane_nx;
      f3_q       <= f3_nx;
      legal_q    <= legal_nx;
      mem_addr   <= mem_addr_nx;
      mem_wdata  <= mem_wdata_nx;
      mem_we_q   <= mem_we_nx;
      mem_re_q   <= mem_re_nx;
      p0_ack     <= p0_ack_nx;
      p1_ack     <= p1_ack_nx;
      p0_err     <= p0_err_nx;
      p1_err     <= p1_err_nx;
    end
  end

  // A reset landing mid-access must not let the pending strobe commit at that edge
  assign mem_we = mem_we_q & {4{~reset}};
  assign mem_re = mem_re_q & ~reset;

  // Load data arrives during RESP, so formatting is combinational on mem_rdata
  always_comb begin
    ld_byte  = mem_rdata[{lane_q, 3'b000} +: 8];
    ld_half  = lane_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    ld_valid = (state == S_RESP) && !we_q && legal_q;
    case (f3_q)
      3'b000:  ld_fmt = {{(DATA_W-8){ld_byte[7]}}, ld_byte};
      3'b001:  ld_fmt = {{(DATA_W-16){ld_half[15]}}, ld_half};
      3'b010:  ld_fmt = mem_rdata;
      3'b100:  ld_fmt = {{(DATA_W-8){1'b0}}, ld_byte};
      3'b101:  ld_fmt = {{(DATA_W-16){1'b0}}, ld_half};
      default: ld_fmt = '0;
    endcase
  end

  assign p0_rdata = (ld_valid && !id_q) ? ld_fmt : '0;
  assign p1_rdata = (ld_valid && id_q)  ? ld_fmt : '0;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: directed scenarios plus randomized single-port
// transactions checked against a byte-level memory model.
module tb_dmem_arbiter;

  localparam int unsigned AW = 9;
  localparam int unsigned DW = 32;

  logic          clk = 1'b0;
  logic          reset;
  logic          p0_req, p0_we, p1_req, p1_we;
  logic [AW-1:0] p0_addr, p1_addr;
  logic [DW-1:0] p0_wdata, p1_wdata;
  logic [2:0]    p0_funct3, p1_funct3;
  logic          p0_ack, p0_err, p1_ack, p1_err;
  logic [DW-1:0] p0_rdata, p1_rdata;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [3:0]    mem_we;
  logic          mem_re;
  logic [DW-1:0] mem_rdata;

  int n_cmp = 0;
  int n_bad = 0;

  logic [31:0] ram [0:127];
  logic [7:0]  ref_mem [0:511];

  always #5 clk = ~clk;

  dmem_arbiter #(.DM_ADDRESS(AW), .DATA_W(DW)) dut (
    .clk(clk), .reset(reset),
    .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
    .p0_funct3(p0_funct3), .p0_ack(p0_ack), .p0_err(p0_err), .p0_rdata(p0_rdata),
    .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
    .p1_funct3(p1_funct3), .p1_ack(p1_ack), .p1_err(p1_err), .p1_rdata(p1_rdata),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_re(mem_re),
    .mem_rdata(mem_rdata)
  );

  // Synchronous-read RAM with byte strobes
  always @(posedge clk) begin
    for (int i = 0; i < 4; i++)
      if (mem_we[i]) ram[mem_addr[8:2]][8*i +: 8] <= mem_wdata[8*i +: 8];
    if (mem_re) mem_rdata <= ram[mem_addr[8:2]];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic set_port(input int port, input logic req, input logic we,
                          input logic [AW-1:0] addr, input logic [DW-1:0] wdata,
                          input logic [2:0] f3);
    if (port == 0) begin
      p0_req = req; p0_we = we; p0_addr = addr; p0_wdata = wdata; p0_funct3 = f3;
    end else begin
      p1_req = req; p1_we = we; p1_addr = addr; p1_wdata = wdata; p1_funct3 = f3;
    end
  endtask

  function automatic int size_of(input logic [2:0] f3);
    return 1 << f3[1:0];
  endfunction

  function automatic logic model_legal(input logic we, input int addr, input logic [2:0] f3);
    if (we && f3 > 3'd2) return 1'b0;
    if (!we && !(f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5})) return 1'b0;
    return (addr % size_of(f3)) == 0;
  endfunction

  function automatic logic [31:0] model_load(input int addr, input logic [2:0] f3);
    int sz;
    logic [31:0] v;
    sz = size_of(f3);
    v  = 32'd0;
    for (int i = 0; i < sz; i++) v = v | (32'(ref_mem[addr+i]) << (8*i));
    if (!f3[2] && sz < 4 && v[8*sz-1]) v = v | ~((32'd1 << (8*sz)) - 32'd1);
    return v;
  endfunction

  task automatic model_store(input int addr, input logic [2:0] f3, input logic [31:0] wdata);
    for (int i = 0; i < size_of(f3); i++) ref_mem[addr+i] = wdata[8*i +: 8];
  endtask

  function automatic logic [31:0] exp_wdata(input logic [2:0] f3, input logic [31:0] wdata);
    case (size_of(f3))
      1:       return 32'(wdata[7:0]) * 32'h0101_0101;
      2:       return 32'(wdata[15:0]) * 32'h0001_0001;
      default: return wdata;
    endcase
  endfunction

  // One transaction on a single port, issued from an IDLE cycle; fixed 3-cycle timeline
  task automatic txn(input int port, input logic we, input logic [AW-1:0] addr,
                     input logic [DW-1:0] wdata, input logic [2:0] f3, input string tag);
    logic        legal;
    logic [31:0] strb, rd, err;
    legal = model_legal(we, int'(addr), f3);
    strb  = ((32'd1 << size_of(f3)) - 32'd1) << (addr % 4);
    set_port(port, 1'b1, we, addr, wdata, f3);
    @(posedge clk); #1;
    chk({tag, " access mem_we"}, 32'(mem_we), (legal && we) ? strb : 32'd0);
    chk({tag, " access mem_re"}, 32'(mem_re), 32'(legal && !we));
    if (legal) chk({tag, " access mem_addr"}, 32'(mem_addr), 32'(addr) & ~32'd3);
    if (legal && we) chk({tag, " access mem_wdata"}, mem_wdata, exp_wdata(f3, wdata));
    chk({tag, " access no ack"}, 32'({p0_ack, p1_ack}), 32'd0);
    @(posedge clk); #1;
    chk({tag, " resp ack"}, 32'({p0_ack, p1_ack}), (port == 0) ? 32'd2 : 32'd1);
    err = (port == 0) ? 32'(p0_err) : 32'(p1_err);
    chk({tag, " resp err"}, err, 32'(!legal));
    rd = (legal && !we) ? model_load(int'(addr), f3) : 32'd0;
    chk({tag, " resp rdata"}, (port == 0) ? p0_rdata : p1_rdata, rd);
    chk({tag, " resp mem idle"}, 32'({mem_we, mem_re}), 32'd0);
    if (legal && we) model_store(int'(addr), f3, wdata);
    set_port(port, 1'b0, 1'b0, '0, '0, 3'd0);
    @(posedge clk); #1;
    chk({tag, " idle no ack"}, 32'({p0_ack, p1_ack, p0_err, p1_err}), 32'd0);
  endtask

  initial begin
    for (int i = 0; i < 128; i++) ram[i] = 32'd0;
    for (int i = 0; i < 512; i++) ref_mem[i] = 8'd0;
    reset = 1'b1;
    set_port(0, 1'b1, 1'b0, 9'h000, 32'd0, 3'b010);
    set_port(1, 1'b1, 1'b0, 9'h004, 32'd0, 3'b010);

    @(posedge clk); #1;
    chk("reset ack/err/re", 32'({p0_ack, p1_ack, p0_err, p1_err, mem_re}), 32'd0);
    chk("reset mem_we", 32'(mem_we), 32'd0);
    chk("reset mem_addr", 32'(mem_addr), 32'd0);
    chk("reset mem_wdata", mem_wdata, 32'd0);
    chk("reset rdata", p0_rdata | p1_rdata, 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;

    // Both ports requesting continuously: p0 first, then alternate every 3 cycles
    for (int c = 1; c <= 12; c++) begin
      @(posedge clk); #1;
      chk($sformatf("alternate ack c%0d", c), 32'({p0_ack, p1_ack}),
          32'({(c % 3 == 2) && ((c / 3) % 2 == 0), (c % 3 == 2) && ((c / 3) % 2 == 1)}));
    end
    set_port(0, 1'b0, 1'b0, '0, '0, 3'd0);
    set_port(1, 1'b0, 1'b0, '0, '0, 3'd0);
    @(posedge clk); #1;

    txn(0, 1'b1, 9'h010, 32'hDEAD_BEEF, 3'b010, "sw 0x10");
    txn(0, 1'b0, 9'h010, 32'd0,         3'b010, "lw 0x10");
    txn(1, 1'b1, 9'h013, 32'h0000_00A5, 3'b000, "sb 0x13");
    txn(1, 1'b0, 9'h013, 32'd0,         3'b000, "lb 0x13");
    txn(1, 1'b0, 9'h013, 32'd0,         3'b100, "lbu 0x13");
    txn(0, 1'b0, 9'h021, 32'd0,         3'b001, "lh 0x21 misaligned");
    txn(0, 1'b1, 9'h022, 32'h1234_5678, 3'b010, "sw 0x22 misaligned");
    txn(0, 1'b1, 9'h010, 32'h8001_7FFF, 3'b010, "sw 0x10 b");
    txn(0, 1'b0, 9'h012, 32'd0,         3'b001, "lh 0x12");
    txn(0, 1'b0, 9'h012, 32'd0,         3'b101, "lhu 0x12");
    txn(0, 1'b0, 9'h010, 32'd0,         3'b001, "lh 0x10");
    txn(1, 1'b0, 9'h010, 32'd0,         3'b011, "load funct3 011");
    txn(1, 1'b1, 9'h010, 32'hFFFF_FFFF, 3'b100, "store funct3 100");

    // Reset during the ACCESS cycle of a store: no write, no ack, p0 wins next
    txn(0, 1'b1, 9'h040, 32'h1122_3344, 3'b010, "sw 0x40");
    set_port(0, 1'b1, 1'b1, 9'h040, 32'hCAFE_F00D, 3'b010);
    @(posedge clk); #1;
    chk("abort access mem_we", 32'(mem_we), 32'hF);
    reset = 1'b1;
    set_port(0, 1'b0, 1'b0, '0, '0, 3'd0);
    #1;
    chk("abort mem_we gated", 32'(mem_we), 32'd0);
    @(posedge clk); #1;
    chk("abort no ack", 32'({p0_ack, p1_ack, p0_err, p1_err}), 32'd0);
    reset = 1'b0;
    set_port(0, 1'b1, 1'b0, 9'h040, 32'd0, 3'b010);
    set_port(1, 1'b1, 1'b0, 9'h044, 32'd0, 3'b010);
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("post-reset p0 first", 32'({p0_ack, p1_ack}), 32'd2);
    chk("post-reset word kept", p0_rdata, model_load(32'h40, 3'b010));
    set_port(0, 1'b0, 1'b0, '0, '0, 3'd0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("post-reset p1 second", 32'({p0_ack, p1_ack}), 32'd1);
    chk("post-reset p1 rdata", p1_rdata, model_load(32'h44, 3'b010));
    set_port(1, 1'b0, 1'b0, '0, '0, 3'd0);
    @(posedge clk); #1;

    for (int k = 0; k < 60; k++) begin
      txn(int'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
          9'(9'h080 + 9'($urandom_range(0, 15))), $urandom,
          3'($urandom_range(0, 7)), $sformatf("random %0d", k));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
